hazard_stall_unit: RTL and testbench

- Pipeline control block that produces stall, hold and flush enables for the pipeline registers.
- It works alongside the EX-stage forwarding logic and covers the hazards forwarding cannot resolve:
  - load-use dependencies, which need an N-cycle bubble;
  - multi-cycle data-memory waits, which freeze the whole pipeline;
  - taken-branch redirects from EX, which squash younger instructions.
- It drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

---
 rtl/hazard_stall_unit.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall/hold/flush control for load-use, memory wait and branch redirect; optional perf counters via HAZARD_PERF_EN
module hazard_stall_unit #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_uses_rs1,
  input  logic        if_id_uses_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        branch_taken_ex,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic        mem_wb_bubble,
  output logic        mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles,
  output logic [31:0] perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_MEM_WAIT,
    ST_FLUSH
  } state_t;

  // Counter reload values: the first bubble/flush cycle is issued from RUN,
  // so the dedicated states only cover the remaining N-1 cycles.
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic [CNT_W-1:0] flush_cnt, flush_nxt;
  logic             timeout_nxt;

  logic load_use;
  logic mem_stall;
  logic freeze_now;
  logic act_freeze;
  logic act_flush;
  logic act_stall;

  // Hazard detection; a load into x0 never creates a dependency.
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
               ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));
    mem_stall = mem_req && !mem_ready;
    // Once waiting, only mem_ready releases the freeze.
    freeze_now = (state == ST_MEM_WAIT) ? !mem_ready : mem_stall;
  end

  // Next-state logic: freeze beats flush beats load-use stall.
  always_comb begin
    state_nxt   = state;
    stall_nxt   = stall_cnt;
    wait_nxt    = wait_cnt;
    flush_nxt   = flush_cnt;
    timeout_nxt = mem_timeout;
    act_freeze  = 1'b0;
    act_flush   = 1'b0;
    act_stall   = 1'b0;

    if (freeze_now) begin
      // Whole pipeline held; any pending stall/flush count is dropped and
      // ID re-evaluates its hazards once the access completes.
      act_freeze = 1'b1;
      state_nxt  = ST_MEM_WAIT;
      stall_nxt  = CNT_ZERO;
      flush_nxt  = CNT_ZERO;
      if (state == ST_MEM_WAIT) begin
        wait_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : (wait_cnt + CNT_ONE);
      end else begin
        wait_nxt = CNT_ONE;
      end
      if ((MEM_TIMEOUT != 0) && (wait_nxt == TIMEOUT_VAL)) begin
        timeout_nxt = 1'b1;
      end
    end else begin
      // Not frozen (includes the mem_ready release cycle): RUN rules apply.
      wait_nxt  = CNT_ZERO;
      state_nxt = ST_RUN;
      if (branch_taken_ex) begin
        act_flush = 1'b1;
        stall_nxt = CNT_ZERO;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = ST_FLUSH;
          flush_nxt = FLUSH_RELOAD;
        end else begin
          flush_nxt = CNT_ZERO;
        end
      end else if (state == ST_FLUSH) begin
        act_flush = 1'b1;
        flush_nxt = flush_cnt - CNT_ONE;
        if (flush_nxt != CNT_ZERO) begin
          state_nxt = ST_FLUSH;
        end
      end else if (state == ST_LOAD_STALL) begin
        act_stall = 1'b1;
        stall_nxt = stall_cnt - CNT_ONE;
        if (stall_nxt != CNT_ZERO) begin
          state_nxt = ST_LOAD_STALL;
        end
      end else if (load_use) begin
        act_stall = 1'b1;
        if (LOAD_USE_STALLS > 1) begin
          state_nxt = ST_LOAD_STALL;
          stall_nxt = STALL_RELOAD;
        end
      end
    end
  end

  // Pipeline register controls; reset forces a plain "advance everything".
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      if (act_freeze) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (act_flush) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (act_stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      stall_cnt   <= CNT_ZERO;
      wait_cnt    <= CNT_ZERO;
      flush_cnt   <= CNT_ZERO;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      stall_cnt   <= stall_nxt;
      wait_cnt    <= wait_nxt;
      flush_cnt   <= flush_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_cycles <= 32'd0;
      perf_wait_cycles  <= 32'd0;
    end else begin
      if (act_stall && !act_flush && !act_freeze) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (act_flush && !act_freeze) begin
        perf_flush_cycles <= perf_flush_cycles + 32'd1;
      end
      if (act_freeze) begin
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit against a cycle-count reference model
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read;
  logic       branch_taken_ex, mem_req, mem_ready;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_timeout}
  wire [7:0] out_a;
  wire [7:0] out_b;
`ifdef HAZARD_PERF_EN
  wire [31:0] pa_s, pa_f, pa_w, pb_s, pb_f, pb_w;
`endif

  always #5 clk = ~clk;

  // Unit 0: default parameters. Unit 1: multi-cycle stall/flush, short timeout.
  hazard_stall_unit dut_a (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(out_a[7]), .if_id_write(out_a[6]), .if_id_flush(out_a[5]),
    .id_ex_write(out_a[4]), .id_ex_bubble(out_a[3]), .ex_mem_write(out_a[2]),
    .mem_wb_bubble(out_a[1]), .mem_timeout(out_a[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(pa_s), .perf_flush_cycles(pa_f), .perf_wait_cycles(pa_w)
`endif
  );

  hazard_stall_unit #(
    .LOAD_USE_STALLS(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(10), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(out_b[7]), .if_id_write(out_b[6]), .if_id_flush(out_b[5]),
    .id_ex_write(out_b[4]), .id_ex_bubble(out_b[3]), .ex_mem_write(out_b[2]),
    .mem_wb_bubble(out_b[1]), .mem_timeout(out_b[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(pb_s), .perf_flush_cycles(pb_f), .perf_wait_cycles(pb_w)
`endif
  );

  // Reference model configuration and state, one slot per unit.
  int          cfg_lus[2] = '{1, 3};
  int          cfg_fc[2]  = '{1, 2};
  int          cfg_mt[2]  = '{255, 10};
  int          bubbles_left[2];
  int          flushes_left[2];
  int          wait_run[2];
  bit          waiting[2];
  bit          timed_out[2];
  logic [31:0] n_stall[2], n_flush[2], n_wait[2];

  typedef struct {
    int          cyc;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [95:0] perf_a;
    logic [95:0] perf_b;
  } sb_entry_t;

  sb_entry_t sbq[$];
  int        cyc_n = 0;
  int        n_checks = 0;
  int        n_pass = 0;

  // One cycle of the behavioural model: decides what the pipeline must do
  // this cycle from the remaining bubble/flush counts and the wait run length.
  function automatic logic [7:0] model_step(input int u);
    logic pw, ifw, fl, idw, bub, emw, mwb, to;
    bit   freeze, lu;
    pw = 1; ifw = 1; fl = 0; idw = 1; bub = 0; emw = 1; mwb = 0;
    to = timed_out[u];
    if (rst) begin
      bubbles_left[u] = 0; flushes_left[u] = 0; wait_run[u] = 0;
      waiting[u] = 0; timed_out[u] = 0;
      n_stall[u] = 0; n_flush[u] = 0; n_wait[u] = 0;
    end else begin
      lu = id_ex_mem_read && (id_ex_rd != 0) &&
           ((if_id_uses_rs1 && if_id_rs1 == id_ex_rd) ||
            (if_id_uses_rs2 && if_id_rs2 == id_ex_rd));
      freeze = waiting[u] ? !mem_ready : (mem_req && !mem_ready);
      if (freeze) begin
        pw = 0; ifw = 0; idw = 0; emw = 0; mwb = 1;
        wait_run[u] = (wait_run[u] < 255) ? wait_run[u] + 1 : 255;
        if (cfg_mt[u] != 0 && wait_run[u] == cfg_mt[u]) timed_out[u] = 1;
        waiting[u] = 1;
        bubbles_left[u] = 0;
        flushes_left[u] = 0;
        n_wait[u] = n_wait[u] + 1;
      end else begin
        waiting[u] = 0;
        wait_run[u] = 0;
        if (branch_taken_ex) begin
          fl = 1; bub = 1;
          flushes_left[u] = cfg_fc[u] - 1;
          bubbles_left[u] = 0;
          n_flush[u] = n_flush[u] + 1;
        end else if (flushes_left[u] > 0) begin
          fl = 1; bub = 1;
          flushes_left[u] = flushes_left[u] - 1;
          n_flush[u] = n_flush[u] + 1;
        end else if (bubbles_left[u] > 0) begin
          pw = 0; ifw = 0; bub = 1;
          bubbles_left[u] = bubbles_left[u] - 1;
          n_stall[u] = n_stall[u] + 1;
        end else if (lu) begin
          pw = 0; ifw = 0; bub = 1;
          bubbles_left[u] = cfg_lus[u] - 1;
          n_stall[u] = n_stall[u] + 1;
        end
      end
    end
    return {pw, ifw, fl, idw, bub, emw, mwb, to};
  endfunction

  // Called right after inputs change: push the expectation, then advance a cycle.
  task automatic cycle();
    sb_entry_t e;
    e.cyc    = cyc_n;
    e.perf_a = {n_stall[0], n_flush[0], n_wait[0]};
    e.perf_b = {n_stall[1], n_flush[1], n_wait[1]};
    e.exp_a  = model_step(0);
    e.exp_b  = model_step(1);
    sbq.push_back(e);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic rq, input logic rdy);
    rst = r; if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_uses_rs1 = u1; if_id_uses_rs2 = u2;
    id_ex_rd = rd; id_ex_mem_read = mr; branch_taken_ex = br; mem_req = rq; mem_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();
    end
  endtask

  task automatic check8(input string nm, input int c, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b exp=%b", nm, c, got, exp);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle, well before posedge.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check8("out_a", e.cyc, out_a, e.exp_a);
        check8("out_b", e.cyc, out_b, e.exp_b);
`ifdef HAZARD_PERF_EN
        n_checks++;
        if ({pa_s, pa_f, pa_w} === e.perf_a) n_pass++;
        else $display("FAIL perf_a cyc=%0d got=%h exp=%h", e.cyc, {pa_s, pa_f, pa_w}, e.perf_a);
        n_checks++;
        if ({pb_s, pb_f, pb_w} === e.perf_b) n_pass++;
        else $display("FAIL perf_b cyc=%0d got=%h exp=%h", e.cyc, {pb_s, pb_f, pb_w}, e.perf_b);
`endif
      end
    end
  end

  initial begin
    int mode;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      bubbles_left[u] = 0; flushes_left[u] = 0; wait_run[u] = 0;
      waiting[u] = 0; timed_out[u] = 0; n_stall[u] = 0; n_flush[u] = 0; n_wait[u] = 0;
    end
    @(negedge clk);

    // Reset, with hazard-looking inputs that must be ignored.
    set_in(1, 5, 0, 1, 0, 5, 1, 1, 1, 0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    idle(1);
    // Load-use on rs1, then on rs2.
    set_in(0, 5, 0, 1, 0, 5, 1, 0, 0, 1); cycle();
    idle(4);
    set_in(0, 1, 7, 0, 1, 7, 1, 0, 0, 1); cycle();
    idle(3);
    // x0 destination and unused-source matches are not hazards.
    set_in(0, 0, 0, 1, 1, 0, 1, 0, 0, 1); cycle(); cycle();
    set_in(0, 9, 9, 0, 0, 9, 1, 0, 0, 1); cycle();
    // Branch coincident with load-use.
    set_in(0, 5, 0, 1, 0, 5, 1, 1, 0, 1); cycle();
    idle(3);
    // Branch during a load stall (unit 1 still has bubbles pending).
    set_in(0, 4, 0, 1, 0, 4, 1, 0, 0, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); cycle();
    idle(3);
    // Memory wait of 4 cycles with a branch held; flush only on release.
    for (int i = 0; i < 4; i++) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); cycle();
    idle(3);
    // Timeout: unit 1 flags after 10 wait cycles and keeps the flag.
    for (int i = 0; i < 12; i++) begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cycle();
    idle(3);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    idle(2);
    // Reset in the middle of a 3-cycle load stall.
    set_in(0, 6, 0, 1, 0, 6, 1, 0, 0, 1); cycle();
    set_in(1, 6, 0, 1, 0, 6, 0, 0, 0, 1); cycle();
    idle(2);

    // Randomised traffic; mode occasionally starves mem_ready to reach timeouts.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) mode = (mode == 0) ? 1 : 0;
      set_in(($urandom_range(0, 299) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
             (mode == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0));
      cycle();
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL sb_drain got=%0d exp=0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
